// File: rtl/rpn_seq_pkg.sv
// Shared constants and FSM state type for the RPN stack sequencer.
// Token kinds, ALU opcodes, result error codes and the sequencer state enum.
package rpn_seq_pkg;

    localparam logic [1:0] TOK_NUM = 2'b00;
    localparam logic [1:0] TOK_ADD = 2'b01;
    localparam logic [1:0] TOK_MUL = 2'b10;
    localparam logic [1:0] TOK_END = 2'b11;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_MALF  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PUSH  = 4'd1,
        S_OP    = 4'd2,
        S_CAPT  = 4'd3,
        S_POP1  = 4'd4,
        S_POP2  = 4'd5,
        S_PUSHR = 4'd6,
        S_FPOP  = 4'd7,
        S_FCAPT = 4'd8,
        S_DRAIN = 4'd9,
        S_FLUSH = 4'd10,
        S_DONE  = 4'd11
    } state_e;

    // Map an operator token onto the ALU command that computes it.
    function automatic logic [2:0] alu_op_of(input logic [1:0] kind);
        logic [2:0] op;
        case (kind)
            TOK_ADD: op = OP_ADD;
            TOK_MUL: op = OP_MUL;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rpn_stack_sequencer.sv
// Drives a stack ALU from a postfix token stream, one command per clock, one result per expression.
// Optional RPN_SEQ_FLUSH_EN: after an error, pop the ALU stack empty before reporting.
module rpn_stack_sequencer
    import rpn_seq_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tok_valid,
    output logic         tok_ready,
    input  logic [1:0]   tok_kind,
    input  logic [W-1:0] tok_value,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_value,
    output logic [1:0]   res_err,
    output logic [2:0]   alu_opcode,
    output logic [W-1:0] alu_data_in,
    input  logic [W-1:0] alu_data_out,
    output logic         busy
);

    localparam logic [SPW-1:0] DEPTH_MAX = SPW'(DEPTH);
    localparam logic [SPW-1:0] ONE       = SPW'(1);
    localparam logic [SPW-1:0] TWO       = SPW'(2);

    state_e         state_q;
    logic [SPW-1:0] depth_q;
    logic [W-1:0]   tmp_q;
    logic [W-1:0]   res_value_q;
    logic [W-1:0]   data_in_q;
    logic [2:0]     opcode_q;
    logic [1:0]     err_q;
    logic           tok_ready_q;
    logic           res_valid_q;
    logic           accept_s;
    logic           go_flush_s;

    assign accept_s = tok_valid && tok_ready_q;

    // End token that must clean up: either ending a drained expression or a malformed one.
    always_comb begin
        go_flush_s = 1'b0;
        if (accept_s && (tok_kind == TOK_END) &&
            ((state_q == S_DRAIN) || ((state_q == S_IDLE) && (depth_q != ONE)))) begin
            go_flush_s = 1'b1;
        end else begin
            go_flush_s = 1'b0;
        end
    end

    // Sequencer FSM; all outputs are registered here and default to idle values each cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            depth_q     <= {SPW{1'b0}};
            tmp_q       <= {W{1'b0}};
            res_value_q <= {W{1'b0}};
            data_in_q   <= {W{1'b0}};
            opcode_q    <= OP_NOP;
            err_q       <= ERR_OK;
            tok_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            opcode_q    <= OP_NOP;
            tok_ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tok_ready_q <= 1'b1;
                    if (accept_s) begin
                        case (tok_kind)
                            TOK_NUM: begin
                                if (depth_q == DEPTH_MAX) begin
                                    err_q   <= ERR_OVER;
                                    state_q <= S_DRAIN;
                                end else begin
                                    tok_ready_q <= 1'b0;
                                    opcode_q    <= OP_PUSH;
                                    data_in_q   <= tok_value;
                                    depth_q     <= depth_q + ONE;
                                    state_q     <= S_PUSH;
                                end
                            end
                            TOK_ADD, TOK_MUL: begin
                                if (depth_q < TWO) begin
                                    err_q   <= ERR_UNDER;
                                    state_q <= S_DRAIN;
                                end else begin
                                    tok_ready_q <= 1'b0;
                                    opcode_q    <= alu_op_of(tok_kind);
                                    state_q     <= S_OP;
                                end
                            end
                            TOK_END: begin
                                tok_ready_q <= 1'b0;
                                if (depth_q == ONE) begin
                                    opcode_q <= OP_POP;
                                    state_q  <= S_FPOP;
                                end else begin
                                    err_q <= ERR_MALF;
                                end
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                S_PUSH: begin
                    tok_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_OP:   state_q <= S_CAPT;
                S_CAPT: begin
                    tmp_q    <= alu_data_out;
                    opcode_q <= OP_POP;
                    state_q  <= S_POP1;
                end
                S_POP1: begin
                    opcode_q <= OP_POP;
                    state_q  <= S_POP2;
                end
                S_POP2: begin
                    opcode_q  <= OP_PUSH;
                    data_in_q <= tmp_q;
                    depth_q   <= depth_q - ONE;
                    state_q   <= S_PUSHR;
                end
                S_PUSHR: begin
                    tok_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                S_FPOP: state_q <= S_FCAPT;
                S_FCAPT: begin
                    res_value_q <= alu_data_out;
                    depth_q     <= {SPW{1'b0}};
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DRAIN: begin
                    tok_ready_q <= !(accept_s && (tok_kind == TOK_END));
                end
                S_FLUSH: begin
`ifdef RPN_SEQ_FLUSH_EN
                    if (depth_q != {SPW{1'b0}}) begin
                        opcode_q <= OP_POP;
                        depth_q  <= depth_q - ONE;
                    end else begin
                        res_value_q <= {W{1'b0}};
                        res_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
`else
                    res_value_q <= {W{1'b0}};
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
`endif
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        res_value_q <= {W{1'b0}};
                        err_q       <= ERR_OK;
                        tok_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // The first pop is issued on entry so a flush of N entries takes N cycles.
            if (go_flush_s) begin
                state_q <= S_FLUSH;
`ifdef RPN_SEQ_FLUSH_EN
                if (depth_q != {SPW{1'b0}}) begin
                    opcode_q <= OP_POP;
                    depth_q  <= depth_q - ONE;
                end
`endif
            end
        end
    end

    assign tok_ready   = tok_ready_q;
    assign res_valid   = res_valid_q;
    assign res_value   = res_value_q;
    assign res_err     = err_q;
    assign alu_opcode  = opcode_q;
    assign alu_data_in = data_in_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Directed bench for rpn_stack_sequencer with a behavioural stack ALU and command trace.
// Expectations follow the build's RPN_SEQ_FLUSH_EN setting.
module tb_rpn_stack_sequencer;
    import rpn_seq_pkg::*;

`ifdef RPN_SEQ_FLUSH_EN
    localparam int FLUSH_EN = 1;
`else
    localparam int FLUSH_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tok_valid = 1'b0;
    logic        tok_ready;
    logic [1:0]  tok_kind = 2'b00;
    logic [31:0] tok_value = 32'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_value;
    logic [1:0]  res_err;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_data_in;
    logic [31:0] alu_data_out;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    rpn_stack_sequencer #(.W(32), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_value(tok_value),
        .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value), .res_err(res_err),
        .alu_opcode(alu_opcode), .alu_data_in(alu_data_in), .alu_data_out(alu_data_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural stack ALU: add/mul leave the stack alone, pop returns the top.
    logic [31:0] stk [0:15];
    logic [4:0]  sp;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp           <= 5'd0;
            alu_data_out <= 32'd0;
        end else begin
            case (alu_opcode)
                3'b110: if (sp < 5'd16) begin
                    stk[4'(sp)] <= alu_data_in;
                    sp <= sp + 5'd1;
                end
                3'b100: if (sp >= 5'd2) alu_data_out <= stk[4'(sp - 5'd1)] + stk[4'(sp - 5'd2)];
                3'b101: if (sp >= 5'd2) alu_data_out <= stk[4'(sp - 5'd1)] * stk[4'(sp - 5'd2)];
                3'b111: if (sp >= 5'd1) begin
                    alu_data_out <= stk[4'(sp - 5'd1)];
                    sp <= sp - 5'd1;
                end
                default: ;
            endcase
        end
    end

    logic [2:0]  tr_op  [$];
    logic [31:0] tr_dat [$];
    always @(posedge clk) begin
        if (rst && alu_opcode != 3'b000) begin
            tr_op.push_back(alu_opcode);
            tr_dat.push_back(alu_data_in);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int count_op(input int base, input logic [2:0] op);
        int c;
        c = 0;
        for (int i = base; i < tr_op.size(); i++) if (tr_op[i] == op) c++;
        return c;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_tok(input logic [1:0] k, input logic [31:0] v);
        int n;
        n = 0;
        tok_valid = 1'b1;
        tok_kind  = k;
        tok_value = v;
        while (!tok_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("tok_accept_timeout", 32'(n >= 100), 32'd0);
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!tok_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic get_res(input string tag, input logic [31:0] ev, input logic [1:0] ee);
        int n;
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_timeout"}, 32'(n >= 200), 32'd0);
        check_eq({tag, "_value"}, res_value, ev);
        check_eq({tag, "_err"}, 32'(res_err), 32'(ee));
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check_eq({tag, "_idle_ready"}, 32'(tok_ready), 32'd1);
    endtask

    logic [2:0]  t1_op  [0:11];
    logic [31:0] t1_dat [0:11];
    int base;
    int lat;

    initial begin
        t1_op  = '{3'b110, 3'b110, 3'b100, 3'b111, 3'b111, 3'b110,
                   3'b110, 3'b101, 3'b111, 3'b111, 3'b110, 3'b111};
        t1_dat = '{32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd7,
                   32'd5, 32'd0, 32'd0, 32'd0, 32'd35, 32'd0};

        // Reset values
        #12;
        check_eq("rst_tok_ready", 32'(tok_ready), 32'd0);
        check_eq("rst_res_valid", 32'(res_valid), 32'd0);
        check_eq("rst_res_value", res_value, 32'd0);
        check_eq("rst_res_err", 32'(res_err), 32'd0);
        check_eq("rst_opcode", 32'(alu_opcode), 32'd0);
        check_eq("rst_data_in", alu_data_in, 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        do_reset();
        check_eq("rel_tok_ready", 32'(tok_ready), 32'd1);

        // 3 4 + 5 * end = 35, with exact command trace
        base = tr_op.size();
        send_tok(TOK_NUM, 32'd3);
        wait_ready(lat);
        check_eq("t1_push_lat", 32'(lat), 32'd1);
        send_tok(TOK_NUM, 32'd4);
        send_tok(TOK_ADD, 32'd0);
        wait_ready(lat);
        check_eq("t1_op_lat", 32'(lat), 32'd5);
        send_tok(TOK_NUM, 32'd5);
        send_tok(TOK_MUL, 32'd0);
        send_tok(TOK_END, 32'd0);
        get_res("t1", 32'd35, ERR_OK);
        check_eq("t1_trace_len", 32'(tr_op.size() - base), 32'd12);
        for (int i = 0; i < 12 && base + i < tr_op.size(); i++) begin
            check_eq("t1_trace_op", 32'(tr_op[base + i]), 32'(t1_op[i]));
            if (t1_op[i] == 3'b110) check_eq("t1_trace_data", tr_dat[base + i], t1_dat[i]);
        end
        check_eq("t1_stack_empty", 32'(sp), 32'd0);

        // 7 end, result held while res_ready stays low
        send_tok(TOK_NUM, 32'd7);
        send_tok(TOK_END, 32'd0);
        lat = 0;
        while (!res_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("t2_hold_valid", 32'(res_valid), 32'd1);
            check_eq("t2_hold_value", res_value, 32'd7);
            check_eq("t2_hold_ready", 32'(tok_ready), 32'd0);
        end
        get_res("t2", 32'd7, ERR_OK);

        // 5 + 9 end: underflow, add never issued, 9 discarded
        do_reset();
        base = tr_op.size();
        send_tok(TOK_NUM, 32'd5);
        send_tok(TOK_ADD, 32'd0);
        send_tok(TOK_NUM, 32'd9);
        send_tok(TOK_END, 32'd0);
        get_res("t3", 32'd0, ERR_UNDER);
        check_eq("t3_no_add", 32'(count_op(base, 3'b100)), 32'd0);
        check_eq("t3_pushes", 32'(count_op(base, 3'b110)), 32'd1);
        check_eq("t3_pops", 32'(count_op(base, 3'b111)), 32'(FLUSH_EN));
        check_eq("t3_stack", 32'(sp), 32'(1 - FLUSH_EN));

        // 17 numbers: overflow on the 17th
        do_reset();
        base = tr_op.size();
        for (int i = 1; i <= 17; i++) send_tok(TOK_NUM, 32'(i));
        send_tok(TOK_END, 32'd0);
        get_res("t4", 32'd0, ERR_OVER);
        check_eq("t4_pushes", 32'(count_op(base, 3'b110)), 32'd16);
        check_eq("t4_pops", 32'(count_op(base, 3'b111)), 32'(16 * FLUSH_EN));

        // 1 2 end: malformed, then + end works on whatever is left
        do_reset();
        base = tr_op.size();
        send_tok(TOK_NUM, 32'd1);
        send_tok(TOK_NUM, 32'd2);
        send_tok(TOK_END, 32'd0);
        get_res("t5", 32'd0, ERR_MALF);
        check_eq("t5_pops", 32'(count_op(base, 3'b111)), 32'(2 * FLUSH_EN));
        send_tok(TOK_ADD, 32'd0);
        send_tok(TOK_END, 32'd0);
        get_res("t5_next", (FLUSH_EN != 0) ? 32'd0 : 32'd3, (FLUSH_EN != 0) ? ERR_UNDER : ERR_OK);

        // Reset during POP1 of an add
        do_reset();
        send_tok(TOK_NUM, 32'd2);
        send_tok(TOK_NUM, 32'd3);
        send_tok(TOK_ADD, 32'd0);
        check_eq("t6_op_add", 32'(alu_opcode), 32'(OP_ADD));
        check_eq("t6_busy", 32'(busy), 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("t6_in_pop1", 32'(alu_opcode), 32'(OP_POP));
        rst = 1'b0;
        #1;
        check_eq("t6_rst_opcode", 32'(alu_opcode), 32'd0);
        check_eq("t6_rst_ready", 32'(tok_ready), 32'd0);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_valid", 32'(res_valid), 32'd0);
        check_eq("t6_rst_data", alu_data_in, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_rel_ready", 32'(tok_ready), 32'd1);
        send_tok(TOK_NUM, 32'd2);
        send_tok(TOK_END, 32'd0);
        get_res("t6", 32'd2, ERR_OK);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rpn_stack_sequencer.md
Name: rpn_stack_sequencer

Overview:
Sequences one stack-based ALU instance to evaluate a postfix (RPN) token stream delivered over a valid/ready handshake, replacing delay-driven, testbench-style command issue with a synthesizable FSM.
Issues one ALU command per clock, tracks stack depth internally, detects underflow/overflow/malformed expressions and returns one result per expression.
Sits between the expression tokenizer (upstream) and the STACK_BASED_ALU (downstream). Both the ALU and this block share clk/rst.

Parameters:
W, 32, operand/result width (matches ALU data width)
DEPTH, 16, ALU stack capacity in entries
SPW, $clog2(DEPTH+1), width of internal depth counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (low = reset)
tok_valid  in  1  token present
tok_ready  out  1  sequencer accepts token this cycle
tok_kind  in  2  00 number, 01 add, 10 mul, 11 end-of-expression
tok_value  in  W  signed operand (number tokens only)
res_valid  out  1  result available, held until res_ready
res_ready  in  1  consumer takes result
res_value  out  W  final value (0 on error)
res_err  out  2  00 ok, 01 underflow, 10 overflow, 11 malformed end
alu_opcode  out  3  000 nop, 100 add, 101 mul, 110 push, 111 pop
alu_data_in  out  W  push operand
alu_data_out  in  W  ALU registered output, valid cycle after command
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, async): state IDLE, depth 0, tok_ready 0, res_valid 0, res_value 0, res_err 00, alu_opcode 000, alu_data_in 0. tok_ready rises on the first clk edge after release. ALU stack is cleared by the same reset. Mid-operation reset abandons the expression with no result.
- Handshakes: a token transfers on posedge when tok_valid&&tok_ready. A result transfers when res_valid&&res_ready. tok_ready=1 only in IDLE and DRAIN.
- alu_opcode is 000 in every state not listed below.
- Number (IDLE): latch value. If depth==DEPTH, set err=10 and go to DRAIN. Otherwise PUSH (opcode 110, data=value, depth+1) -> IDLE. Back-to-back throughput: 1 number per 2 cycles.
- Operator (IDLE): if depth<2, set err=01 and go to DRAIN; no ALU command is issued. Otherwise:
  - OP (100/101)
  - CAPT (nop; latch alu_data_out into tmp)
  - POP1 (111)
  - POP2 (111)
  - PUSHR (110, data=tmp)
  - -> IDLE
  - Net depth change -1; latency 5 cycles from accept to tok_ready.
- Arithmetic is performed by the ALU, wrapping modulo 2^W. The sequencer does no arithmetic besides the depth counter.
- End (IDLE): if depth==1, FPOP (111) -> FCAPT (latch alu_data_out into res_value, depth 0) -> DONE. If depth!=1, set err=11 -> FLUSH.
- DRAIN: accept and discard tokens until the end token, then FLUSH. The first error wins; later errors are ignored.
- FLUSH: see Optional Feature. Then DONE with res_value=0.
- DONE: res_valid=1, outputs stable until res_ready, then IDLE with err cleared.
- Simultaneous tok_valid during DONE: not accepted (tok_ready=0).

Optional Feature:
RPN_SEQ_FLUSH_EN:
- Defined: FLUSH issues one pop (111) per cycle until depth==0, so the ALU stack is empty for the next expression. Latency is depth cycles.
- Undefined: FLUSH is a single-cycle pass-through. Stack contents and the depth counter are retained, and the next expression operates on the leftover stack. Software must reset after an error.

Decomposition:
- Package rpn_seq_pkg holds:
  - token-kind constants
  - ALU opcode constants (NOP/ADD/MUL/PUSH/POP)
  - res_err codes
  - FSM state enum: IDLE, PUSH, OP, CAPT, POP1, POP2, PUSHR, FPOP, FCAPT, DRAIN, FLUSH, DONE
- No sub-module: the ALU is instantiated by the parent, and depth tracking stays inline.

Test Plan:
- Tokens 3,4,+,5,*,end -> res_value 35, err 00; ALU command trace push3, push4, add, pop, pop, push7, push5, mul, pop, pop, push35, pop; alu stack empty afterwards.
- 7,end with res_ready low for 10 cycles -> res_valid held 10 cycles, value 7 stable; tok_ready 0 throughout.
- 5,+,9,end (FLUSH_EN) -> err 01, value 0, no add issued, "9" discarded, one flush pop, then IDLE with depth 0.
- DEPTH=16: 17 numbers, end -> err 10 on the 17th; with FLUSH_EN, 16 pops are issued before DONE.
- 1,2,end -> err 11; FLUSH_EN: 2 pops. Without FLUSH_EN: 0 pops, and next expression +,end returns 3.
- Assert rst low during POP1 of an add -> outputs at reset values immediately; after release, 2,end returns 2 (depth restarted at 0).
